regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single write port of the 15-entry ARM register file between two writeback
//   sources: the pipeline WB stage (A, back-pressurable) and the SRAM load-return path
//   (B, one-cycle pulse, never stalls). B always wins. A is written directly when the port
//   is free, else queued. Drives write_back_en/dest_wb/result_wb; flags read/write hazards
//   against queued writes so ID can stall.
// PARAMETERS
//   DATA_W  32  write data width
//   ADDR_W  4   register index width
//   DEPTH   4   A-side queue entries; power of two, >= 2
// PORTS
//   clk         in   1       clock; all state updates on posedge
//   rst         in   1       reset, synchronous, active-high
//   a_valid     in   1       pipeline WB write request
//   a_dest      in   ADDR_W  pipeline WB destination
//   a_data      in   DATA_W  pipeline WB data
//   a_ready     out  1       A accepted this cycle when a_valid & a_ready
//   b_valid     in   1       SRAM load-return write (single-cycle pulse)
//   b_dest      in   ADDR_W  load destination
//   b_data      in   DATA_W  load data
//   chk_src1    in   ADDR_W  ID-stage source 1 to check
//   chk_src2    in   ADDR_W  ID-stage source 2 to check
//   chk_dest    in   ADDR_W  ID-stage destination to check
//   chk_en      in   3       per-field check enables {dest,src2,src1}
//   hazard      out  1       a checked register has a pending write
//   wb_en       out  1       to register file write_back_en
//   wb_dest     out  ADDR_W  to register file dest_wb
//   wb_data     out  DATA_W  to register file result_wb
//   q_count     out  clog2(DEPTH)+1  queued A entries
// BEHAVIOUR
//   - Reset: wb_en=0, wb_dest=0, wb_data=0, queue empty, q_count=0; a_ready=1 next cycle.
//   - Per-cycle select, priority: (1) b_valid -> B; (2) queue non-empty -> pop head;
//     (3) a_valid & a_ready -> A direct. Selected write registered into wb_* at posedge:
//     latency 1 cycle; register file samples on the following negedge.
//   - A accepted but not selected -> pushed to queue tail; order of A writes preserved.
//   - a_ready = (q_count < DEPTH), registered-state only (no path from b_valid).
//   - Queue full: a_ready=0; push and pop same cycle keep q_count unchanged.
//   - dest==15 (PC, not in file): request accepted, consumes its slot, but wb_en=0.
//   - hazard (combinational) = any enabled chk field equals dest of a valid queue entry or
//     of the wb_* stage with wb_en=1, or equals a_dest while a_valid, or b_dest while
//     b_valid. chk index 15 never hazards.
//   - Upstream contract: no two in-flight writes to the same register (hazard enforces);
//     two writes to one register in one cycle are undefined.
//   - rst mid-operation: queue flushed, pending writes discarded, wb_en=0 next cycle.
//   - B arriving every cycle starves the queue; a_ready drops once full; no data lost.
// STRUCTURE
//   - Package arm_rf_pkg: REG_COUNT=15, PC_IDX=4'd15, DATA_W/ADDR_W defaults, wb_req_t
//     {dest,data}.
//   - Sub-module wb_req_fifo: DEPTH-entry circular queue, wrap-around pointers, exposes all
//     entry dests + valids for hazard compare.
//   - Top: select mux, wb_* output register, hazard comparators.
// TESTING
//   - rst=1 then A(r3,0x11) alone -> next cycle wb_en=1,wb_dest=3,wb_data=0x11; q_count=0.
//   - Same cycle A(r3,0x11) and B(r5,0x22) -> cycle1 r5/0x22, cycle2 r3/0x11, q_count 1->0.
//   - B held valid 6 cycles, A valid each cycle -> a_ready=0 after 4 pushes; queue drains
//     A in order once B stops; 6 B then 4 A writes, none lost or reordered.
//   - A(r7) queued, chk_src2=7 chk_en=3'b010 -> hazard=1 until r7 leaves wb_* stage, then 0.
//   - A(r15,0xFF) -> wb_en stays 0, slot consumed; chk_src1=15 -> hazard=0.
//   - Queue holds 3 entries, rst asserted 1 cycle -> wb_en=0, q_count=0, no queued write issued.

Source files
------------

// File: rtl/arm_rf_pkg.sv
// Shared constants and types for the ARM register-file writeback path.
// The register file holds r0..r14; index 15 is the PC and lives outside it.
package arm_rf_pkg;

   localparam int REG_COUNT      = 15;
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 4;
   localparam logic [DEFAULT_ADDR_W-1:0] PC_IDX = 4'd15;

   typedef struct packed {
      logic [DEFAULT_ADDR_W-1:0] dest;
      logic [DEFAULT_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Circular queue of deferred pipeline writebacks. Every entry's destination and
// occupancy are exported so the top level can compare them against ID-stage operands.
module wb_req_fifo
   import arm_rf_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_push,
   input  logic [ADDR_W-1:0]             i_push_dest,
   input  logic [DATA_W-1:0]             i_push_data,
   input  logic                          i_pop,
   output logic [ADDR_W-1:0]             o_head_dest,
   output logic [DATA_W-1:0]             o_head_data,
   output logic [CNT_W-1:0]              o_count,
   output logic                          o_empty,
   output logic [DEPTH-1:0][ADDR_W-1:0]  o_ent_dest,
   output logic [DEPTH-1:0]              o_ent_valid
);

   logic [DEPTH-1:0][ADDR_W-1:0] r_dest;
   logic [DATA_W-1:0]            r_data [DEPTH];
   logic [DEPTH-1:0]             r_vld;
   logic [PTR_W-1:0]             r_wr_ptr;
   logic [PTR_W-1:0]             r_rd_ptr;
   logic [CNT_W-1:0]             r_count;

   // Pointers wrap for free because DEPTH is a power of two. The caller never pushes
   // when full nor pops when empty, so a same-cycle push and pop never share a slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dest   <= '0;
      end else begin
         if (i_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + 1'b1;
         end
         if (i_push) begin
            r_vld[r_wr_ptr]  <= 1'b1;
            r_dest[r_wr_ptr] <= i_push_dest;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_data[r_wr_ptr] <= i_push_data;
   end

   assign o_head_dest = r_dest[r_rd_ptr];
   assign o_head_data = r_data[r_rd_ptr];
   assign o_count     = r_count;
   assign o_empty     = (r_count == '0);
   assign o_ent_dest  = r_dest;
   assign o_ent_valid = r_vld;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the pipeline WB stage (A,
// queued when blocked) and SRAM load returns (B, always wins), and flags ID-stage hazards.
module regfile_wb_arbiter
   import arm_rf_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_dest,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_dest,
   input  logic [DATA_W-1:0] b_data,
   input  logic [ADDR_W-1:0] chk_src1,
   input  logic [ADDR_W-1:0] chk_src2,
   input  logic [ADDR_W-1:0] chk_dest,
   input  logic [2:0]        chk_en,
   output logic              hazard,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic [CNT_W-1:0]  q_count
);

   function automatic logic is_rf_reg(input logic [ADDR_W-1:0] d);
      return int'(d) < REG_COUNT;
   endfunction

   logic                         w_a_ready;
   logic                         w_a_acc;
   logic                         w_push;
   logic                         w_pop;
   logic                         w_sel_vld;
   logic [ADDR_W-1:0]            w_sel_dest;
   logic [DATA_W-1:0]            w_sel_data;
   logic [ADDR_W-1:0]            w_head_dest;
   logic [DATA_W-1:0]            w_head_data;
   logic [CNT_W-1:0]             w_count;
   logic                         w_empty;
   logic [DEPTH-1:0][ADDR_W-1:0] w_ent_dest;
   logic [DEPTH-1:0]             w_ent_valid;
   logic [2:0][ADDR_W-1:0]       w_chk;
   logic                         w_hazard;

   logic                         r_wb_en;
   logic [ADDR_W-1:0]            r_wb_dest;
   logic [DATA_W-1:0]            r_wb_data;

   wb_req_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_dest (a_dest),
      .i_push_data (a_data),
      .i_pop       (w_pop),
      .o_head_dest (w_head_dest),
      .o_head_data (w_head_data),
      .o_count     (w_count),
      .o_empty     (w_empty),
      .o_ent_dest  (w_ent_dest),
      .o_ent_valid (w_ent_valid)
   );

   // Ready depends only on queue occupancy, keeping b_valid off the A handshake path.
   assign w_a_ready = (w_count < CNT_W'(DEPTH));
   assign w_a_acc   = a_valid & w_a_ready;

   always_comb begin
      w_sel_vld  = 1'b0;
      w_sel_dest = '0;
      w_sel_data = '0;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      if (b_valid) begin
         w_sel_vld  = 1'b1;
         w_sel_dest = b_dest;
         w_sel_data = b_data;
         w_push     = w_a_acc;
      end else if (!w_empty) begin
         w_sel_vld  = 1'b1;
         w_sel_dest = w_head_dest;
         w_sel_data = w_head_data;
         w_pop      = 1'b1;
         w_push     = w_a_acc;
      end else if (w_a_acc) begin
         w_sel_vld  = 1'b1;
         w_sel_dest = a_dest;
         w_sel_data = a_data;
      end
   end

   // A PC-destined request still occupies its issue slot but never enables the write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_en   <= 1'b0;
         r_wb_dest <= '0;
         r_wb_data <= '0;
      end else begin
         r_wb_en <= w_sel_vld & is_rf_reg(w_sel_dest);
         if (w_sel_vld) begin
            r_wb_dest <= w_sel_dest;
            r_wb_data <= w_sel_data;
         end
      end
   end

   assign w_chk = {chk_dest, chk_src2, chk_src1};

   always_comb begin
      w_hazard = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (chk_en[k] && is_rf_reg(w_chk[k])) begin
            if (r_wb_en && (r_wb_dest == w_chk[k])) w_hazard = 1'b1;
            if (a_valid && (a_dest == w_chk[k]))    w_hazard = 1'b1;
            if (b_valid && (b_dest == w_chk[k]))    w_hazard = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
               if (w_ent_valid[j] && (w_ent_dest[j] == w_chk[k])) w_hazard = 1'b1;
            end
         end
      end
   end

   assign a_ready = w_a_ready;
   assign hazard  = w_hazard;
   assign wb_en   = r_wb_en;
   assign wb_dest = r_wb_dest;
   assign wb_data = r_wb_data;
   assign q_count = w_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter: a queue-level model predicts
// the order of register-file writes, queue occupancy, a_ready and hazard.
module tb_regfile_wb_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_valid = 1'b0;
   logic [AW-1:0] a_dest = '0;
   logic [DW-1:0] a_data = '0;
   logic          a_ready;
   logic          b_valid = 1'b0;
   logic [AW-1:0] b_dest = '0;
   logic [DW-1:0] b_data = '0;
   logic [AW-1:0] chk_src1 = '0;
   logic [AW-1:0] chk_src2 = '0;
   logic [AW-1:0] chk_dest = '0;
   logic [2:0]    chk_en = '0;
   logic          hazard;
   logic          wb_en;
   logic [AW-1:0] wb_dest;
   logic [DW-1:0] wb_data;
   logic [2:0]    q_count;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_valid  (a_valid),
      .a_dest   (a_dest),
      .a_data   (a_data),
      .a_ready  (a_ready),
      .b_valid  (b_valid),
      .b_dest   (b_dest),
      .b_data   (b_data),
      .chk_src1 (chk_src1),
      .chk_src2 (chk_src2),
      .chk_dest (chk_dest),
      .chk_en   (chk_en),
      .hazard   (hazard),
      .wb_en    (wb_en),
      .wb_dest  (wb_dest),
      .wb_data  (wb_data),
      .q_count  (q_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model / scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [AW+DW-1:0] exp_q[$];   // register-file writes still to be observed, in order
   logic [AW+DW-1:0] mq[$];      // model of A requests waiting for the port
   logic             last_en = 1'b0;
   logic [AW-1:0]    last_dest = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic pending(input logic [AW-1:0] r);
      if (r == 4'd15) return 1'b0;
      foreach (mq[i]) if (mq[i][AW+DW-1:DW] == r) return 1'b1;
      if (last_en && last_dest == r) return 1'b1;
      if (a_valid && a_dest == r) return 1'b1;
      if (b_valid && b_dest == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic model_hazard();
      logic h;
      h = 1'b0;
      if (chk_en[0] && pending(chk_src1)) h = 1'b1;
      if (chk_en[1] && pending(chk_src2)) h = 1'b1;
      if (chk_en[2] && pending(chk_dest)) h = 1'b1;
      return h;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (wb_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got r%0d=%0h expected no write", wb_dest, wb_data);
         end else begin
            e = exp_q.pop_front();
            check("wb_write", {wb_dest, wb_data}, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; applies one cycle of stimulus and returns at the next posedge+1.
   task automatic step(input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] adt,
                       input logic bv, input logic [AW-1:0] bd, input logic [DW-1:0] bdt,
                       output logic acc);
      logic          exp_rdy;
      logic          sel;
      logic [AW+DW-1:0] req;
      exp_rdy = (mq.size() < DEPTH);
      check("a_ready", a_ready, exp_rdy);
      a_valid = av; a_dest = ad; a_data = adt;
      b_valid = bv; b_dest = bd; b_data = bdt;
      #1;
      check("hazard", hazard, model_hazard());
      acc = av && exp_rdy;
      sel = 1'b1;
      if (bv) begin
         req = {bd, bdt};
         if (acc) mq.push_back({ad, adt});
      end else if (mq.size() > 0) begin
         req = mq.pop_front();
         if (acc) mq.push_back({ad, adt});
      end else if (acc) begin
         req = {ad, adt};
      end else begin
         sel = 1'b0;
         req = '0;
      end
      last_en   = sel && (req[AW+DW-1:DW] != 4'd15);
      last_dest = req[AW+DW-1:DW];
      if (last_en) exp_q.push_back(req);
      @(posedge clk); #1;
      check("wb_en", wb_en, last_en);
      check("q_count", q_count, mq.size());
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, acc);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; chk_en = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete();
      exp_q.delete();
      last_en = 1'b0;
      check("rst_wb_en", wb_en, 1'b0);
      check("rst_wb_dest", wb_dest, '0);
      check("rst_wb_data", wb_data, '0);
      check("rst_q_count", q_count, '0);
      check("rst_a_ready", a_ready, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic          acc;
      int            na;
      logic          ra_v;
      logic [AW-1:0] ra_d;
      logic [DW-1:0] ra_dt;

      repeat (2) @(posedge clk);
      do_reset();

      // Lone A write goes straight through.
      step(1'b1, 4'd3, 32'h11, 1'b0, '0, '0, acc);
      idle(1);

      // A and B together: B first, A one cycle later via the queue.
      step(1'b1, 4'd3, 32'h11, 1'b1, 4'd5, 32'h22, acc);
      idle(2);

      // B every cycle starves the queue until it is full.
      na = 0;
      for (int c = 0; c < 6; c++) begin
         step(na < 4, 4'(na + 1), 32'hA0 + na, 1'b1, 4'(c + 9), 32'hB0 + c, acc);
         if (acc) na++;
      end
      check("a_accepted", na, 4);
      idle(6);

      // Queued r7 hazards until it has left the wb stage.
      do_reset();
      step(1'b1, 4'd7, 32'h77, 1'b1, 4'd2, 32'h20, acc);
      chk_src2 = 4'd7; chk_en = 3'b010;
      idle(3);
      chk_en = 3'b000;

      // PC destination: slot consumed, no register-file write, never a hazard.
      chk_src1 = 4'd15; chk_en = 3'b001;
      step(1'b1, 4'd15, 32'hFF, 1'b1, 4'd4, 32'h44, acc);
      idle(2);
      chk_en = 3'b000;

      // Reset with three queued entries discards them.
      for (int c = 0; c < 3; c++) step(1'b1, 4'(c + 1), 32'hC0 + c, 1'b1, 4'(c + 8), 32'hD0 + c, acc);
      do_reset();
      chk_src1 = 4'd1; chk_src2 = 4'd2; chk_dest = 4'd3; chk_en = 3'b111;
      idle(3);

      // Random traffic with A held steady until accepted.
      ra_v = 1'b0; ra_d = '0; ra_dt = '0;
      for (int c = 0; c < 400; c++) begin
         if (!ra_v) begin
            ra_v  = ($urandom_range(0, 9) < 6);
            ra_d  = 4'($urandom_range(0, 15));
            ra_dt = $urandom;
         end
         chk_src1 = 4'($urandom_range(0, 15));
         chk_src2 = 4'($urandom_range(0, 15));
         chk_dest = 4'($urandom_range(0, 15));
         chk_en   = 3'($urandom_range(0, 7));
         step(ra_v, ra_d, ra_dt, ($urandom_range(0, 9) < 4),
              4'($urandom_range(0, 15)), $urandom, acc);
         if (acc) ra_v = 1'b0;
      end

      chk_en = 3'b000;
      for (int i = 0; i < 20 && mq.size() > 0; i++) idle(1);
      idle(2);
      check("exp_q_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
